// File: rtl/quad_velocity_filter.sv
// Quadrature velocity filter: integrates signed per-window pulse counts into a
// position and keeps a TAPS-long moving average of the counts.
module quad_velocity_filter #(
    parameter int CNT_W = 5,
    parameter int POS_W = 24,
    parameter int TAPS  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic [CNT_W-1:0] cnt_in,
    input  logic             cnt_valid,
    output logic [POS_W-1:0] pos,
    output logic [CNT_W-1:0] avg,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             settled,
    output logic             overrun,
    output logic             state_dbg
);

    localparam int PTR_W = $clog2(TAPS);
    localparam int SUM_W = CNT_W + PTR_W;
    localparam logic [PTR_W-1:0] PTR_LAST = {PTR_W{1'b1}};

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic [CNT_W-1:0] buf_q [TAPS];
    logic [PTR_W-1:0] wptr_q;
    logic [PTR_W-1:0] fill_q;
    logic [SUM_W-1:0] sum_q;
    logic [POS_W-1:0] pos_q;
    logic             out_valid_q;
    logic             overrun_q;

    logic             accept;
    logic [CNT_W-1:0] old_cnt;
    logic [SUM_W-1:0] new_ext_sum;
    logic [SUM_W-1:0] old_ext_sum;
    logic [POS_W-1:0] new_ext_pos;

    // clr has priority; a coincident strobe is dropped.
    assign accept      = cnt_valid & ~clr;
    assign old_cnt     = buf_q[wptr_q];
    assign new_ext_sum = {{PTR_W{cnt_in[CNT_W-1]}}, cnt_in};
    assign old_ext_sum = {{PTR_W{old_cnt[CNT_W-1]}}, old_cnt};
    assign new_ext_pos = {{(POS_W-CNT_W){cnt_in[CNT_W-1]}}, cnt_in};

    always_comb begin
        state_d = state_q;
        if (clr) begin
            state_d = FILL;
        end else if (accept && state_q == FILL && fill_q == PTR_LAST) begin
            state_d = RUN;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FILL;
        end else begin
            state_q <= state_d;
        end
    end

    // Output handshake: a pos/avg pair is offered while out_valid is high and is
    // consumed on any edge where out_valid && out_ready; a new sample always
    // replaces the held pair, flagging overrun only if it was not consumed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pos_q       <= '0;
            sum_q       <= '0;
            wptr_q      <= '0;
            fill_q      <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
            for (int i = 0; i < TAPS; i++) buf_q[i] <= '0;
        end else if (clr) begin
            pos_q       <= '0;
            sum_q       <= '0;
            wptr_q      <= '0;
            fill_q      <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
            for (int i = 0; i < TAPS; i++) buf_q[i] <= '0;
        end else begin
            if (accept) begin
                pos_q          <= pos_q + new_ext_pos;
                sum_q          <= sum_q + new_ext_sum - old_ext_sum;
                buf_q[wptr_q]  <= cnt_in;
                wptr_q         <= wptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
                out_valid_q    <= 1'b1;
                if (state_q == FILL) begin
                    fill_q <= fill_q + {{(PTR_W-1){1'b0}}, 1'b1};
                end
                if (out_valid_q && !out_ready) begin
                    overrun_q <= 1'b1;
                end
            end else if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    // Top CNT_W bits of the sum are the floor-divided average.
    assign avg       = sum_q[PTR_W +: CNT_W];
    assign pos       = pos_q;
    assign out_valid = out_valid_q;
    assign overrun   = overrun_q;
    assign settled   = (state_q == RUN);
    assign state_dbg = state_q;

endmodule

// File: tb/tb_quad_velocity_filter.sv
// Directed bench for quad_velocity_filter: a CNT_W=5/TAPS=4 instance at POS_W=24
// and a second at POS_W=8 for position wrap, both driven from the same inputs.
module tb_quad_velocity_filter;

    logic       clk;
    logic       rst;
    logic       clr;
    logic [4:0] cnt_in;
    logic       cnt_valid;
    logic       out_ready;

    logic [23:0] pos;
    logic [4:0]  avg;
    logic        out_valid, settled, overrun, state_dbg;

    logic [7:0]  pos8;
    logic [4:0]  avg8;
    logic        out_valid8, settled8, overrun8, state_dbg8;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] got, exp_v;
    logic [9:0]  got8, exp8;

    quad_velocity_filter #(.CNT_W(5), .POS_W(24), .TAPS(4)) u_dut (
        .clk(clk), .rst(rst), .clr(clr), .cnt_in(cnt_in), .cnt_valid(cnt_valid),
        .pos(pos), .avg(avg), .out_valid(out_valid), .out_ready(out_ready),
        .settled(settled), .overrun(overrun), .state_dbg(state_dbg)
    );

    quad_velocity_filter #(.CNT_W(5), .POS_W(8), .TAPS(4)) u_dut8 (
        .clk(clk), .rst(rst), .clr(clr), .cnt_in(cnt_in), .cnt_valid(cnt_valid),
        .pos(pos8), .avg(avg8), .out_valid(out_valid8), .out_ready(out_ready),
        .settled(settled8), .overrun(overrun8), .state_dbg(state_dbg8)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver: inputs change on the falling edge, outputs are sampled on the
    // following falling edge, after the rising edge has consumed the inputs.
    task automatic step(input logic v, input logic [4:0] c, input logic r, input logic cl);
        cnt_valid = v;
        cnt_in    = c;
        out_ready = r;
        clr       = cl;
        @(negedge clk);
    endtask

    task automatic do_clr();
        step(1'b0, 5'd0, 1'b1, 1'b1);
        step(1'b0, 5'd0, 1'b1, 1'b0);
    endtask

    // Each check packs {pos, avg, out_valid, settled, overrun}.
    task automatic test_reset();
        #12;
        n_checks++; got = {pos, avg, out_valid, settled, overrun}; exp_v = 32'd0;
        if (got !== exp_v) begin n_fail++; $display("FAIL reset_outputs got %h exp %h", got, exp_v); end
        n_checks++;
        if (state_dbg !== 1'b0) begin n_fail++; $display("FAIL reset_state got %b exp 0", state_dbg); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_fill_avg();
        do_clr();
        step(1'b1, 5'd3, 1'b1, 1'b0);
        n_checks++; got = {pos, avg, out_valid, settled, overrun}; exp_v = {24'd3, 5'd0, 3'b100};
        if (got !== exp_v) begin n_fail++; $display("FAIL fill_1 got %h exp %h", got, exp_v); end
        step(1'b1, 5'd3, 1'b1, 1'b0);
        n_checks++; got = {pos, avg, out_valid, settled, overrun}; exp_v = {24'd6, 5'd1, 3'b100};
        if (got !== exp_v) begin n_fail++; $display("FAIL fill_2 got %h exp %h", got, exp_v); end
        step(1'b1, 5'd3, 1'b1, 1'b0);
        n_checks++; got = {pos, avg, out_valid, settled, overrun}; exp_v = {24'd9, 5'd2, 3'b100};
        if (got !== exp_v) begin n_fail++; $display("FAIL fill_3 got %h exp %h", got, exp_v); end
        step(1'b1, 5'd3, 1'b1, 1'b0);
        n_checks++; got = {pos, avg, out_valid, settled, overrun}; exp_v = {24'd12, 5'd3, 3'b110};
        if (got !== exp_v) begin n_fail++; $display("FAIL fill_4 got %h exp %h", got, exp_v); end
        n_checks++;
        if (state_dbg !== 1'b1) begin n_fail++; $display("FAIL run_state got %b exp 1", state_dbg); end
        // In RUN the oldest +3 is evicted: sum 12-3-5=4, then 4-3+15=16.
        step(1'b1, 5'h1B, 1'b1, 1'b0);
        n_checks++; got = {pos, avg, out_valid, settled, overrun}; exp_v = {24'd7, 5'd1, 3'b110};
        if (got !== exp_v) begin n_fail++; $display("FAIL run_evict1 got %h exp %h", got, exp_v); end
        step(1'b1, 5'd15, 1'b1, 1'b0);
        n_checks++; got = {pos, avg, out_valid, settled, overrun}; exp_v = {24'd22, 5'd4, 3'b110};
        if (got !== exp_v) begin n_fail++; $display("FAIL run_evict2 got %h exp %h", got, exp_v); end
        step(1'b0, 5'd0, 1'b1, 1'b0);
        n_checks++; got = {pos, avg, out_valid, settled, overrun}; exp_v = {24'd22, 5'd4, 3'b010};
        if (got !== exp_v) begin n_fail++; $display("FAIL handshake_clear got %h exp %h", got, exp_v); end
    endtask

    task automatic test_negative();
        do_clr();
        n_checks++; got = {pos, avg, out_valid, settled, overrun}; exp_v = 32'd0;
        if (got !== exp_v) begin n_fail++; $display("FAIL clr_state got %h exp %h", got, exp_v); end
        step(1'b1, 5'h1F, 1'b1, 1'b0);
        n_checks++; got = {pos, avg, out_valid, settled, overrun}; exp_v = {24'hFFFFFF, 5'h1F, 3'b100};
        if (got !== exp_v) begin n_fail++; $display("FAIL neg_floor got %h exp %h", got, exp_v); end
    endtask

    task automatic test_overrun();
        do_clr();
        step(1'b1, 5'd2, 1'b0, 1'b0);
        n_checks++; got = {pos, avg, out_valid, settled, overrun}; exp_v = {24'd2, 5'd0, 3'b100};
        if (got !== exp_v) begin n_fail++; $display("FAIL ovr_first got %h exp %h", got, exp_v); end
        step(1'b1, 5'd2, 1'b0, 1'b0);
        n_checks++; got = {pos, avg, out_valid, settled, overrun}; exp_v = {24'd4, 5'd1, 3'b101};
        if (got !== exp_v) begin n_fail++; $display("FAIL ovr_set got %h exp %h", got, exp_v); end
        step(1'b0, 5'd0, 1'b0, 1'b0);
        step(1'b0, 5'd0, 1'b0, 1'b0);
        n_checks++; got = {pos, avg, out_valid, settled, overrun}; exp_v = {24'd4, 5'd1, 3'b101};
        if (got !== exp_v) begin n_fail++; $display("FAIL ovr_hold got %h exp %h", got, exp_v); end
        step(1'b0, 5'd0, 1'b1, 1'b0);
        n_checks++; got = {pos, avg, out_valid, settled, overrun}; exp_v = {24'd4, 5'd1, 3'b001};
        if (got !== exp_v) begin n_fail++; $display("FAIL ovr_sticky got %h exp %h", got, exp_v); end
    endtask

    task automatic test_back_to_back();
        do_clr();
        step(1'b1, 5'd1, 1'b0, 1'b0);
        step(1'b1, 5'd1, 1'b1, 1'b0);
        n_checks++; got = {pos, avg, out_valid, settled, overrun}; exp_v = {24'd2, 5'd0, 3'b100};
        if (got !== exp_v) begin n_fail++; $display("FAIL b2b_handshake got %h exp %h", got, exp_v); end
        step(1'b1, 5'd6, 1'b1, 1'b0);
        n_checks++; got = {pos, avg, out_valid, settled, overrun}; exp_v = {24'd8, 5'd2, 3'b100};
        if (got !== exp_v) begin n_fail++; $display("FAIL b2b_third got %h exp %h", got, exp_v); end
    endtask

    task automatic test_pos_wrap();
        do_clr();
        for (int i = 0; i < 8; i++) step(1'b1, 5'd15, 1'b1, 1'b0);
        step(1'b1, 5'd7, 1'b1, 1'b0);
        n_checks++; got8 = {pos8, out_valid8, overrun8}; exp8 = {8'h7F, 2'b10};
        if (got8 !== exp8) begin n_fail++; $display("FAIL wrap_preload got %h exp %h", got8, exp8); end
        step(1'b1, 5'd1, 1'b1, 1'b0);
        n_checks++; got8 = {pos8, out_valid8, overrun8}; exp8 = {8'h80, 2'b10};
        if (got8 !== exp8) begin n_fail++; $display("FAIL wrap_neg got %h exp %h", got8, exp8); end
        n_checks++;
        if (pos !== 24'd128) begin n_fail++; $display("FAIL wrap_wide got %0d exp 128", pos); end
    endtask

    task automatic test_clr_run();
        do_clr();
        for (int i = 0; i < 4; i++) step(1'b1, 5'd3, 1'b1, 1'b0);
        step(1'b1, 5'd5, 1'b1, 1'b1);
        n_checks++; got = {pos, avg, out_valid, settled, overrun}; exp_v = 32'd0;
        if (got !== exp_v) begin n_fail++; $display("FAIL clr_wins got %h exp %h", got, exp_v); end
        step(1'b1, 5'd4, 1'b1, 1'b0);
        n_checks++; got = {pos, avg, out_valid, settled, overrun}; exp_v = {24'd4, 5'd1, 3'b100};
        if (got !== exp_v) begin n_fail++; $display("FAIL clr_resume got %h exp %h", got, exp_v); end
    endtask

    task automatic test_async_reset();
        do_clr();
        step(1'b1, 5'd3, 1'b0, 1'b0);
        step(1'b1, 5'd3, 1'b0, 1'b0);
        step(1'b1, 5'd3, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        n_checks++; got = {pos, avg, out_valid, settled, overrun}; exp_v = 32'd0;
        if (got !== exp_v) begin n_fail++; $display("FAIL async_rst got %h exp %h", got, exp_v); end
        @(negedge clk);
        rst = 1'b0;
        step(1'b1, 5'd3, 1'b1, 1'b0);
        n_checks++; got = {pos, avg, out_valid, settled, overrun}; exp_v = {24'd3, 5'd0, 3'b100};
        if (got !== exp_v) begin n_fail++; $display("FAIL rst_resume got %h exp %h", got, exp_v); end
    endtask

    initial begin
        rst       = 1'b1;
        clr       = 1'b0;
        cnt_in    = 5'd0;
        cnt_valid = 1'b0;
        out_ready = 1'b1;
        test_reset();
        test_fill_avg();
        test_negative();
        test_overrun();
        test_back_to_back();
        test_pos_wrap();
        test_clr_run();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
